// File: rtl/dma_multichannel_reader_if.sv
// Request/bus bundle of the multi-channel read DMA: channel requests, memory read port
// and captured buffer. The DMA engine takes the master side.
interface dma_multichannel_reader_if #(
    parameter int NUM_CH            = 2,
    parameter int BUFFER_SIZE       = 120,
    parameter int WORD_SIZE         = 16,
    parameter int MEM_ADDRESS_WIDTH = 10
);
    logic [NUM_CH-1:0]                         i_req;
    logic [NUM_CH-1:0][MEM_ADDRESS_WIDTH-1:0]  i_address;
    logic [NUM_CH-1:0][MEM_ADDRESS_WIDTH-1:0]  i_count;
    logic [NUM_CH-1:0][MEM_ADDRESS_WIDTH-1:0]  i_stride;
    logic [NUM_CH-1:0]                         o_ack;
    logic                                      o_mem_rd;
    logic [MEM_ADDRESS_WIDTH-1:0]              o_mem_addr;
    logic [WORD_SIZE-1:0]                      i_mem_data;
    logic [BUFFER_SIZE-1:0][WORD_SIZE-1:0]     o_buffer;
    logic                                      o_busy;
    logic                                      o_ready;
    logic [$clog2(NUM_CH):0]                   o_ready_ch;

    modport master (
        input  i_req, i_address, i_count, i_stride, i_mem_data,
        output o_ack, o_mem_rd, o_mem_addr, o_buffer, o_busy, o_ready, o_ready_ch
    );
    modport slave (
        output i_req, i_address, i_count, i_stride, i_mem_data,
        input  o_ack, o_mem_rd, o_mem_addr, o_buffer, o_busy, o_ready, o_ready_ch
    );
endinterface

// File: rtl/dma_multichannel_reader.sv
// Round-robin multi-channel read DMA: strided reads from a synchronous memory with
// fixed read latency, captured in order into a shared local buffer.
module dma_multichannel_reader #(
    parameter int NUM_CH            = 2,
    parameter int BUFFER_SIZE       = 120,
    parameter int WORD_SIZE         = 16,
    parameter int MEM_ADDRESS_WIDTH = 10,
    parameter int MEM_LATENCY       = 1
) (
    input  logic clk,
    input  logic rst,
    dma_multichannel_reader_if.master bus
);
    localparam int AW  = MEM_ADDRESS_WIDTH;
    localparam int PW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CHW = $clog2(NUM_CH) + 1;
    localparam int CW  = $clog2(BUFFER_SIZE + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                                state_q;
    logic [PW-1:0]                         rr_q, ch_q;
    logic [CW-1:0]                         n_q, iss_q, wr_q;
    logic [AW-1:0]                         stride_q, mem_addr_q;
    logic                                  mem_rd_q, busy_q, ready_q;
    logic [NUM_CH-1:0]                     ack_q;
    logic [CHW-1:0]                        ready_ch_q;
    logic [MEM_LATENCY-1:0]                vld_q;
    logic [BUFFER_SIZE-1:0][WORD_SIZE-1:0] buf_q;

    logic          gnt_vld;
    logic [PW-1:0] gnt_idx;
    logic [AW-1:0] sel_cnt;
    logic [CW-1:0] n_d;
    logic          cap;
    logic          drained;

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!gnt_vld && bus.i_req[(int'(rr_q) + i) % NUM_CH]) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'((int'(rr_q) + i) % NUM_CH);
            end
        end
    end

    always_comb begin
        sel_cnt = bus.i_count[gnt_idx];
        if (int'(sel_cnt) > BUFFER_SIZE) n_d = CW'(BUFFER_SIZE);
        else                             n_d = CW'(sel_cnt);
    end

    // Reads return in issue order, so a running write index is enough.
    assign cap     = vld_q[MEM_LATENCY-1];
    assign drained = (n_q == '0) || (cap && (wr_q + CW'(1) == n_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            ch_q       <= '0;
            n_q        <= '0;
            iss_q      <= '0;
            wr_q       <= '0;
            stride_q   <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            ack_q      <= '0;
            ready_ch_q <= '0;
            vld_q      <= '0;
            buf_q      <= '0;
        end else begin
            ack_q    <= '0;
            vld_q[0] <= mem_rd_q;
            for (int i = 1; i < MEM_LATENCY; i++) vld_q[i] <= vld_q[i-1];
            if (cap) begin
                buf_q[wr_q] <= bus.i_mem_data;
                wr_q        <= wr_q + CW'(1);
            end
            case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        state_q        <= ISSUE;
                        ack_q[gnt_idx] <= 1'b1;
                        busy_q         <= 1'b1;
                        rr_q           <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + PW'(1);
                        ch_q           <= gnt_idx;
                        n_q            <= n_d;
                        stride_q       <= bus.i_stride[gnt_idx];
                        mem_addr_q     <= bus.i_address[gnt_idx];
                        mem_rd_q       <= (n_d != '0);
                        iss_q          <= (n_d != '0) ? CW'(1) : '0;
                        wr_q           <= '0;
                    end
                end
                ISSUE: begin
                    if (iss_q == n_q) begin
                        mem_rd_q <= 1'b0;
                        state_q  <= DRAIN;
                    end else begin
                        mem_addr_q <= mem_addr_q + stride_q;
                        iss_q      <= iss_q + CW'(1);
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        ready_q    <= 1'b1;
                        ready_ch_q <= CHW'(ch_q);
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    ready_q    <= 1'b0;
                    ready_ch_q <= '0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_ack      = ack_q;
    assign bus.o_mem_rd   = mem_rd_q;
    assign bus.o_mem_addr = mem_addr_q;
    assign bus.o_buffer   = buf_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_ready    = ready_q;
    assign bus.o_ready_ch = ready_ch_q;
endmodule

// File: tb/tb_dma_multichannel_reader.sv
// Bench: two DMA instances (read latency 1 and 3) fed identical transfers, checked
// cycle by cycle against a transfer-level model of grant order, timing and buffer.
module tb_dma_multichannel_reader;
    localparam int NC  = 2;
    localparam int BS  = 120;
    localparam int WS  = 16;
    localparam int AW  = 10;
    localparam int CHW = $clog2(NC) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    dma_multichannel_reader_if #(.NUM_CH(NC), .BUFFER_SIZE(BS), .WORD_SIZE(WS), .MEM_ADDRESS_WIDTH(AW)) b1 ();
    dma_multichannel_reader_if #(.NUM_CH(NC), .BUFFER_SIZE(BS), .WORD_SIZE(WS), .MEM_ADDRESS_WIDTH(AW)) b3 ();

    dma_multichannel_reader #(.NUM_CH(NC), .BUFFER_SIZE(BS), .WORD_SIZE(WS),
        .MEM_ADDRESS_WIDTH(AW), .MEM_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    dma_multichannel_reader #(.NUM_CH(NC), .BUFFER_SIZE(BS), .WORD_SIZE(WS),
        .MEM_ADDRESS_WIDTH(AW), .MEM_LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    // Per-instance stimulus and observation, index 0 = latency 1, index 1 = latency 3
    logic [NC-1:0]         req_v  [2];
    logic [NC-1:0][AW-1:0] addr_v [2];
    logic [NC-1:0][AW-1:0] cnt_v  [2];
    logic [NC-1:0][AW-1:0] str_v  [2];
    logic [NC-1:0]         ack_o  [2];
    logic                  rd_o   [2];
    logic                  busy_o [2];
    logic                  rdy_o  [2];
    logic [AW-1:0]         addr_o [2];
    logic [CHW-1:0]        rch_o  [2];
    logic [BS-1:0][WS-1:0] buf_o  [2];

    assign b1.i_req = req_v[0];  assign b1.i_address = addr_v[0];
    assign b1.i_count = cnt_v[0]; assign b1.i_stride = str_v[0];
    assign b3.i_req = req_v[1];  assign b3.i_address = addr_v[1];
    assign b3.i_count = cnt_v[1]; assign b3.i_stride = str_v[1];
    assign ack_o[0] = b1.o_ack;   assign ack_o[1] = b3.o_ack;
    assign rd_o[0] = b1.o_mem_rd; assign rd_o[1] = b3.o_mem_rd;
    assign busy_o[0] = b1.o_busy; assign busy_o[1] = b3.o_busy;
    assign rdy_o[0] = b1.o_ready; assign rdy_o[1] = b3.o_ready;
    assign addr_o[0] = b1.o_mem_addr; assign addr_o[1] = b3.o_mem_addr;
    assign rch_o[0] = b1.o_ready_ch;  assign rch_o[1] = b3.o_ready_ch;
    assign buf_o[0] = b1.o_buffer;    assign buf_o[1] = b3.o_buffer;

    // Synchronous memory models with 1 and 3 cycles of read latency
    logic [WS-1:0] mem [1024];
    logic [WS-1:0] p1;
    logic [WS-1:0] p3 [3];
    always @(posedge clk) begin
        p1    <= rd_o[0] ? mem[addr_o[0]] : 16'hDEAD;
        p3[0] <= rd_o[1] ? mem[addr_o[1]] : 16'hBEEF;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign b1.i_mem_data = p1;
    assign b3.i_mem_data = p3[2];

    // Reference model state
    int            rr_m;
    logic [WS-1:0] ebuf [BS];
    logic [AW-1:0] t_a [NC];
    logic [AW-1:0] t_c [NC];
    logic [AW-1:0] t_s [NC];

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic model_clear();
        rr_m = 0;
        for (int k = 0; k < BS; k++) ebuf[k] = '0;
    endtask

    // Presents the channels in mask with t_a/t_c/t_s on both instances and checks the
    // whole sequence of transfers they produce.
    task automatic serve(input logic [NC-1:0] mask, input string nm);
        logic [NC-1:0] pend;
        int            order [NC];
        int            nn [NC];
        int            ackj [2][NC];
        int            rdyj [2][NC];
        logic [WS-1:0] snap [NC][BS];
        logic [AW-1:0] eaddr [$];
        logic [AW-1:0] gq0 [$];
        logic [AW-1:0] gq1 [$];
        int            ntx, jmax;

        pend = mask;
        ntx  = 0;
        while (pend != '0) begin
            int g;
            g = -1;
            for (int i = 0; i < NC; i++)
                if (g < 0 && pend[(rr_m + i) % NC]) g = (rr_m + i) % NC;
            pend[g] = 1'b0;
            rr_m    = (g + 1) % NC;
            nn[ntx] = (int'(t_c[g]) > BS) ? BS : int'(t_c[g]);
            order[ntx] = g;
            for (int k = 0; k < nn[ntx]; k++) begin
                logic [AW-1:0] ad;
                ad = AW'(int'(t_a[g]) + k * int'(t_s[g]));
                eaddr.push_back(ad);
                ebuf[k] = mem[ad];
            end
            for (int k = 0; k < BS; k++) snap[ntx][k] = ebuf[k];
            for (int d = 0; d < 2; d++) begin
                ackj[d][ntx] = (ntx == 0) ? 1 : rdyj[d][ntx-1] + 2;
                rdyj[d][ntx] = ackj[d][ntx] + ((nn[ntx] > 0) ? nn[ntx] + lat(d) : 2);
            end
            ntx++;
        end
        jmax = ((rdyj[0][ntx-1] > rdyj[1][ntx-1]) ? rdyj[0][ntx-1] : rdyj[1][ntx-1]) + 2;

        for (int d = 0; d < 2; d++) begin
            req_v[d] = mask;
            for (int c = 0; c < NC; c++) begin
                addr_v[d][c] = t_a[c]; cnt_v[d][c] = t_c[c]; str_v[d][c] = t_s[c];
            end
        end

        for (int j = 1; j <= jmax; j++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                logic [NC-1:0]  e_ack;
                logic           e_rdy, e_busy;
                logic [CHW-1:0] e_ch;
                e_ack = '0; e_rdy = 1'b0; e_busy = 1'b0; e_ch = '0;
                for (int t = 0; t < ntx; t++) begin
                    if (j == ackj[d][t]) e_ack[order[t]] = 1'b1;
                    if (j == rdyj[d][t]) begin e_rdy = 1'b1; e_ch = CHW'(order[t]); end
                    if (j >= ackj[d][t] && j <= rdyj[d][t]) e_busy = 1'b1;
                end
                n_chk++;
                if (ack_o[d] !== e_ack) begin
                    n_fail++;
                    $display("FAIL %s ack L%0d j=%0d: got %b want %b", nm, lat(d), j, ack_o[d], e_ack);
                end
                n_chk++;
                if (rdy_o[d] !== e_rdy) begin
                    n_fail++;
                    $display("FAIL %s ready L%0d j=%0d: got %b want %b", nm, lat(d), j, rdy_o[d], e_rdy);
                end
                n_chk++;
                if (busy_o[d] !== e_busy) begin
                    n_fail++;
                    $display("FAIL %s busy L%0d j=%0d: got %b want %b", nm, lat(d), j, busy_o[d], e_busy);
                end
                if (e_rdy) begin
                    n_chk++;
                    if (rch_o[d] !== e_ch) begin
                        n_fail++;
                        $display("FAIL %s ready_ch L%0d: got %0d want %0d", nm, lat(d), rch_o[d], e_ch);
                    end
                end
                if (rd_o[d] === 1'b1) begin
                    if (d == 0) gq0.push_back(addr_o[d]);
                    else        gq1.push_back(addr_o[d]);
                end
                for (int t = 0; t < ntx; t++) begin
                    if (j == rdyj[d][t]) begin
                        int bad;
                        bad = 0;
                        for (int k = 0; k < BS; k++) if (buf_o[d][k] !== snap[t][k]) bad++;
                        n_chk++;
                        if (bad != 0) begin
                            n_fail++;
                            $display("FAIL %s buffer L%0d xfer %0d: %0d words differ, want 0", nm, lat(d), t, bad);
                        end
                    end
                    if (j == ackj[d][t]) begin
                        // Granted channel drops its request; its inputs are scrambled.
                        req_v[d][order[t]]  = 1'b0;
                        addr_v[d][order[t]] = AW'($urandom);
                        cnt_v[d][order[t]]  = AW'($urandom);
                        str_v[d][order[t]]  = AW'($urandom);
                    end
                end
            end
        end

        for (int d = 0; d < 2; d++) begin
            int bad, sz;
            bad = 0;
            sz  = (d == 0) ? gq0.size() : gq1.size();
            for (int k = 0; k < eaddr.size() && k < sz; k++)
                if (((d == 0) ? gq0[k] : gq1[k]) !== eaddr[k]) bad++;
            n_chk++;
            if (sz != eaddr.size() || bad != 0) begin
                n_fail++;
                $display("FAIL %s addr_seq L%0d: got %0d reads (%0d wrong), want %0d reads",
                         nm, lat(d), sz, bad, eaddr.size());
            end
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            req_v[d] = '0; addr_v[d] = '0; cnt_v[d] = '0; str_v[d] = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if ({ack_o[d], rd_o[d], addr_o[d], busy_o[d], rdy_o[d], rch_o[d]} !== '0 || buf_o[d] !== '0) begin
                n_fail++;
                $display("FAIL reset_state L%0d: ack=%b rd=%b addr=%0d busy=%b rdy=%b ch=%0d, want all 0",
                         lat(d), ack_o[d], rd_o[d], addr_o[d], busy_o[d], rdy_o[d], rch_o[d]);
            end
        end
    endtask

    task automatic test_basic();
        t_a[0] = 10; t_c[0] = 4; t_s[0] = 1;
        serve(2'b01, "basic");
    endtask

    task automatic test_round_robin();
        t_a[0] = 100; t_c[0] = 3; t_s[0] = 1;
        t_a[1] = 300; t_c[1] = 5; t_s[1] = 3;
        serve(2'b11, "rr_dual0");
        t_a[0] = 50; t_c[0] = 2; t_s[0] = 7;
        serve(2'b01, "rr_single");
        t_a[0] = 700; t_c[0] = 4; t_s[0] = 1;
        t_a[1] = 900; t_c[1] = 2; t_s[1] = 1;
        serve(2'b11, "rr_dual1");
    endtask

    task automatic test_clamp();
        t_a[1] = AW'($urandom); t_c[1] = 200; t_s[1] = 1;
        serve(2'b10, "clamp");
    endtask

    task automatic test_wrap();
        t_a[0] = 1020; t_c[0] = 6; t_s[0] = 2;
        serve(2'b01, "wrap");
    endtask

    task automatic test_zero();
        t_a[1] = 33; t_c[1] = 0; t_s[1] = 1;
        serve(2'b10, "zero");
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [NC-1:0] m;
            m = NC'($urandom_range(1, 3));
            for (int c = 0; c < NC; c++) begin
                int sel;
                sel    = $urandom_range(0, 3);
                t_a[c] = AW'($urandom);
                t_s[c] = AW'($urandom);
                t_c[c] = (sel == 0) ? AW'(0) : (sel == 3) ? AW'($urandom_range(110, 130))
                                                          : AW'($urandom_range(1, 9));
            end
            serve(m, "random");
        end
    endtask

    task automatic test_reset_mid();
        for (int d = 0; d < 2; d++) begin
            req_v[d] = 2'b01; addr_v[d][0] = 200; cnt_v[d][0] = 10; str_v[d][0] = 1;
        end
        repeat (4) @(negedge clk);
        rst = 1'b1;
        for (int d = 0; d < 2; d++) req_v[d] = '0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if ({ack_o[d], rd_o[d], addr_o[d], busy_o[d], rdy_o[d], rch_o[d]} !== '0 || buf_o[d] !== '0) begin
                n_fail++;
                $display("FAIL reset_mid L%0d: rd=%b addr=%0d busy=%b rdy=%b, want all 0 and buffer clear",
                         lat(d), rd_o[d], addr_o[d], busy_o[d], rdy_o[d]);
            end
        end
        rst = 1'b0;
        model_clear();
        for (int d = 0; d < 2; d++) begin
            int seen;
            seen = 0;
            for (int j = 0; j < 20; j++) begin
                if (d == 0) @(negedge clk);
                if (rdy_o[d] === 1'b1 || rd_o[d] === 1'b1) seen++;
            end
            n_chk++;
            if (seen != 0) begin
                n_fail++;
                $display("FAIL reset_mid_quiet L%0d: %0d active cycles, want 0", lat(d), seen);
            end
        end
        t_a[1] = 5; t_c[1] = 3; t_s[1] = 4;
        serve(2'b10, "after_reset");
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = WS'($urandom);
        test_reset();
        test_basic();
        test_round_robin();
        test_clamp();
        test_wrap();
        test_zero();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
